// File: rtl/sec_a2b_iter_if.sv
// sec_a2b_iter_if: bus bundle for the iterative arithmetic-to-Boolean converter.
// Groups the upstream handshake (i_valid/i_ready/i_a), the randomness port
// (rnd/rnd_req), the downstream handshake (o_valid/o_ready/o_z) and busy.
// Shares are packed with share j at [j*K_WIDTH +: K_WIDTH].
// Modports:
//   master - the environment side (drives inputs, observes results)
//   slave  - the converter side
interface sec_a2b_iter_if #(
   parameter int K_WIDTH  = 32,
   parameter int N_SHARES = 4
);
   localparam int W    = N_SHARES * K_WIDTH;
   localparam int RNDW = N_SHARES * (N_SHARES - 1) * K_WIDTH;

   logic            i_valid;
   logic            i_ready;
   logic [W-1:0]    i_a;
   logic [RNDW-1:0] rnd;
   logic            rnd_req;
   logic            o_valid;
   logic            o_ready;
   logic [W-1:0]    o_z;
   logic            busy;

   modport master (
      output i_valid, i_a, rnd, o_ready,
      input  i_ready, rnd_req, o_valid, o_z, busy
   );

   modport slave (
      input  i_valid, i_a, rnd, o_ready,
      output i_ready, rnd_req, o_valid, o_z, busy
   );
endinterface

// File: rtl/sec_a2b_iter.sv
// sec_a2b_iter: iterative, any-order arithmetic-to-Boolean mask converter.
// Converts N_SHARES arithmetic shares (mod 2^K_WIDTH) into N_SHARES Boolean
// shares of the same secret by accumulating N_SHARES-1 masked Kogge-Stone
// additions through one time-multiplexed pair of DOM-AND gadgets.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - sec_a2b_iter_if.slave: i_valid/i_ready/i_a in, rnd/rnd_req,
//           o_valid/o_ready/o_z out, busy
module sec_a2b_iter #(
   parameter int K_WIDTH  = 32,
   parameter int N_SHARES = 4
) (
   input logic           clk,
   input logic           rst_n,
   sec_a2b_iter_if.slave bus
);
   localparam int L        = $clog2(K_WIDTH - 1);
   localparam int W        = N_SHARES * K_WIDTH;
   localparam int NPAIR    = N_SHARES * (N_SHARES - 1) / 2;
   localparam int PW       = NPAIR * K_WIDTH;
   localparam int RNDW     = 2 * PW;
   localparam int JW       = $clog2(N_SHARES);
   localparam int RW       = (L > 1) ? $clog2(L) : 1;
   localparam int LAST_R   = (L > 0) ? L - 1 : 0;
   localparam bit NO_PREFIX = (L == 0);

   typedef enum logic [1:0] {IDLE, GEN, PREFIX, DONE} state_t;

   state_t          state, state_next;
   logic [W-1:0]    buf_a, x, p, g;
   logic [JW-1:0]   op_idx;
   logic [RW-1:0]   round;
   logic [W-1:0]    y, and0, and1, g_next, x_sum;
   logic            add_done, last_op, gen;
   int              shift;

   // Index of the randomness word shared by shares i and k (lexicographic, i<k).
   function automatic int pair_idx(input int i, input int k);
      int lo, hi;
      lo = (i < k) ? i : k;
      hi = (i < k) ? k : i;
      return lo * (2 * N_SHARES - lo - 1) / 2 + (hi - lo - 1);
   endfunction

   // Per-share logical left shift; bits leaving the top of a share are dropped.
   function automatic logic [W-1:0] shl(input logic [W-1:0] v, input int s);
      logic [W-1:0] res;
      res = '0;
      for (int i = 0; i < N_SHARES; i++)
         res[i*K_WIDTH +: K_WIDTH] = v[i*K_WIDTH +: K_WIDTH] << s;
      return res;
   endfunction

   // DOM-independent AND: each cross term is blinded by the pair's word, which
   // appears in exactly two output shares and therefore cancels in the XOR.
   function automatic logic [W-1:0] sec_and(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [PW-1:0] m);
      logic [W-1:0] z;
      z = '0;
      for (int i = 0; i < N_SHARES; i++) begin
         z[i*K_WIDTH +: K_WIDTH] = a[i*K_WIDTH +: K_WIDTH] & b[i*K_WIDTH +: K_WIDTH];
         for (int k = 0; k < N_SHARES; k++) begin
            if (k != i)
               z[i*K_WIDTH +: K_WIDTH] = z[i*K_WIDTH +: K_WIDTH]
                  ^ (a[i*K_WIDTH +: K_WIDTH] & b[k*K_WIDTH +: K_WIDTH])
                  ^ m[pair_idx(i, k)*K_WIDTH +: K_WIDTH];
         end
      end
      return z;
   endfunction

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   assign last_op = (op_idx == JW'(N_SHARES - 1));

   // Next-state and handshake outputs. An addition finishes either on the last
   // prefix round or, when there are no prefix rounds (K_WIDTH=2), in GEN.
   always_comb begin
      state_next  = state;
      add_done    = 1'b0;
      bus.i_ready = 1'b0;
      bus.rnd_req = 1'b0;
      bus.busy    = 1'b0;
      bus.o_valid = 1'b0;
      bus.o_z     = '0;
      case (state)
         IDLE: begin
            bus.i_ready = 1'b1;
            if (bus.i_valid) state_next = GEN;
         end
         GEN: begin
            bus.rnd_req = 1'b1;
            bus.busy    = 1'b1;
            if (NO_PREFIX) begin
               add_done   = 1'b1;
               state_next = last_op ? DONE : GEN;
            end else begin
               state_next = PREFIX;
            end
         end
         PREFIX: begin
            bus.rnd_req = 1'b1;
            bus.busy    = 1'b1;
            if (round == RW'(LAST_R)) begin
               add_done   = 1'b1;
               state_next = last_op ? DONE : GEN;
            end
         end
         DONE: begin
            bus.o_valid = 1'b1;
            bus.o_z     = x;
            if (bus.o_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Gadget operand steering. GEN forms g = x&y with gadget 0; PREFIX uses
   // gadget 0 for the generate update and gadget 1 for the propagate update.
   always_comb begin
      y                  = '0;
      y[K_WIDTH-1:0]     = buf_a[int'(op_idx)*K_WIDTH +: K_WIDTH];
      shift              = 1 << round;
      gen                = (state == GEN);
      and0               = sec_and(gen ? x : p, gen ? y : shl(g, shift), bus.rnd[0 +: PW]);
      and1               = sec_and(p, shl(p, shift), bus.rnd[PW +: PW]);
      g_next             = gen ? and0 : (g ^ and0);
      x_sum              = x ^ y ^ shl(g_next, 1);
   end

   // Datapath registers: share buffer, Boolean accumulator x, prefix p/g and
   // the operand and round counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_a  <= '0;
         x      <= '0;
         p      <= '0;
         g      <= '0;
         op_idx <= '0;
         round  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_valid) begin
                  buf_a  <= bus.i_a;
                  x      <= {{(W-K_WIDTH){1'b0}}, bus.i_a[K_WIDTH-1:0]};
                  op_idx <= JW'(1);
               end
            end
            GEN: begin
               p     <= x ^ y;
               g     <= g_next;
               round <= '0;
            end
            PREFIX: begin
               g     <= g_next;
               round <= round + 1'b1;
               if (round != RW'(LAST_R)) p <= and1;
            end
            default: ;
         endcase
         if (add_done) begin
            x <= x_sum;
            if (!last_op) op_idx <= op_idx + 1'b1;
         end
      end
   end

   logic unused_rnd;
   assign unused_rnd = ^bus.rnd[RNDW-1:RNDW-1];
endmodule

// File: tb/tb_sec_a2b_iter.sv
// tb_sec_a2b_iter: scoreboard bench for sec_a2b_iter.
// Three instances: N=4/K=32 (main), N=2/K=8 and N=5/K=32. Drivers push the
// expected XOR of the output shares into a per-instance queue on acceptance;
// monitors pop and compare on every o_valid&&o_ready, also checking latency
// and the number of rnd_req cycles.
module tb_sec_a2b_iter;
   typedef struct {
      logic [31:0] x;
      int          acc;
   } exp_t;

   localparam int LAT_A = 18;
   localparam int LAT_B = 4;
   localparam int LAT_C = 24;

   logic clk;
   logic rst_n;
   int   cyc;
   int   total;
   int   bad;
   bit   rnd_zero;
   exp_t qa[$], qb[$], qc[$];
   int   last_acc;
   logic [127:0] last_z_a;

   sec_a2b_iter_if #(.K_WIDTH(32), .N_SHARES(4)) a_if();
   sec_a2b_iter_if #(.K_WIDTH(8),  .N_SHARES(2)) b_if();
   sec_a2b_iter_if #(.K_WIDTH(32), .N_SHARES(5)) c_if();

   sec_a2b_iter #(.K_WIDTH(32), .N_SHARES(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
   sec_a2b_iter #(.K_WIDTH(8),  .N_SHARES(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
   sec_a2b_iter #(.K_WIDTH(32), .N_SHARES(5)) dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Fresh randomness every cycle (or all zero when rnd_zero is set).
   always @(negedge clk) begin
      for (int w = 0; w < 12; w++) a_if.rnd[w*32 +: 32] = rnd_zero ? 32'h0 : $urandom;
      for (int w = 0; w < 20; w++) c_if.rnd[w*32 +: 32] = rnd_zero ? 32'h0 : $urandom;
      b_if.rnd = rnd_zero ? 16'h0 : 16'($urandom);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] xorA(input logic [127:0] z);
      logic [31:0] r = 0;
      for (int i = 0; i < 4; i++) r ^= z[i*32 +: 32];
      return r;
   endfunction

   function automatic logic [31:0] xorC(input logic [159:0] z);
      logic [31:0] r = 0;
      for (int i = 0; i < 5; i++) r ^= z[i*32 +: 32];
      return r;
   endfunction

   // Monitors: one per instance.
   int cnt_a, cnt_b, cnt_c, rise_a, rise_b, rise_c;
   bit prev_a, prev_b, prev_c;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         cnt_a = 0; prev_a = 0;
      end else begin
         if (a_if.rnd_req) cnt_a++;
         if (a_if.o_valid && !prev_a) rise_a = cyc;
         prev_a = a_if.o_valid;
         if (a_if.o_valid && a_if.o_ready) begin
            if (qa.size() == 0) checkOutput("A_unexpected", 1, 0);
            else begin
               e = qa.pop_front();
               checkOutput("A_xor", xorA(a_if.o_z), e.x);
               checkOutput("A_latency", rise_a - e.acc, LAT_A);
               checkOutput("A_rnd_req_cycles", cnt_a, LAT_A);
            end
            last_z_a = a_if.o_z;
            cnt_a = 0;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         cnt_b = 0; prev_b = 0;
      end else begin
         if (b_if.rnd_req) cnt_b++;
         if (b_if.o_valid && !prev_b) rise_b = cyc;
         prev_b = b_if.o_valid;
         if (b_if.o_valid && b_if.o_ready) begin
            if (qb.size() == 0) checkOutput("B_unexpected", 1, 0);
            else begin
               e = qb.pop_front();
               checkOutput("B_xor", {24'h0, b_if.o_z[7:0] ^ b_if.o_z[15:8]}, e.x);
               checkOutput("B_latency", rise_b - e.acc, LAT_B);
               checkOutput("B_rnd_req_cycles", cnt_b, LAT_B);
            end
            cnt_b = 0;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         cnt_c = 0; prev_c = 0;
      end else begin
         if (c_if.rnd_req) cnt_c++;
         if (c_if.o_valid && !prev_c) rise_c = cyc;
         prev_c = c_if.o_valid;
         if (c_if.o_valid && c_if.o_ready) begin
            if (qc.size() == 0) checkOutput("C_unexpected", 1, 0);
            else begin
               e = qc.pop_front();
               checkOutput("C_xor", xorC(c_if.o_z), e.x);
               checkOutput("C_latency", rise_c - e.acc, LAT_C);
               checkOutput("C_rnd_req_cycles", cnt_c, LAT_C);
            end
            cnt_c = 0;
         end
      end
   end

   // Drivers: present a vector, wait (bounded) for acceptance, push expectation.
   task automatic applyStimulus(input logic [127:0] a, input logic [31:0] exp);
      exp_t e;
      int n = 0;
      a_if.i_a = a;
      a_if.i_valid = 1'b1;
      while (!a_if.i_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
         checkOutput("A_accept_timeout", 0, 1);
      end else begin
         @(posedge clk); #1;
         e.x = exp; e.acc = cyc; last_acc = cyc;
         qa.push_back(e);
      end
      a_if.i_valid = 1'b0;
   endtask

   task automatic applyStimulusB(input logic [15:0] a, input logic [7:0] exp);
      exp_t e;
      int n = 0;
      b_if.i_a = a;
      b_if.i_valid = 1'b1;
      while (!b_if.i_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
         checkOutput("B_accept_timeout", 0, 1);
      end else begin
         @(posedge clk); #1;
         e.x = {24'h0, exp}; e.acc = cyc;
         qb.push_back(e);
      end
      b_if.i_valid = 1'b0;
   endtask

   task automatic applyStimulusC(input logic [159:0] a, input logic [31:0] exp);
      exp_t e;
      int n = 0;
      c_if.i_a = a;
      c_if.i_valid = 1'b1;
      while (!c_if.i_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
         checkOutput("C_accept_timeout", 0, 1);
      end else begin
         @(posedge clk); #1;
         e.x = exp; e.acc = cyc;
         qc.push_back(e);
      end
      c_if.i_valid = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      while ((qa.size() + qb.size() + qc.size()) != 0 && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) begin
         checkOutput(name, qa.size() + qb.size() + qc.size(), 0);
         qa.delete(); qb.delete(); qc.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic checkResetA(input string tag);
      checkOutput({tag, "_i_ready"}, a_if.i_ready, 1);
      checkOutput({tag, "_o_valid"}, a_if.o_valid, 0);
      checkOutput({tag, "_rnd_req"}, a_if.rnd_req, 0);
      checkOutput({tag, "_busy"}, a_if.busy, 0);
      checkOutput({tag, "_o_z_zero"}, a_if.o_z == '0, 1);
   endtask

   initial begin
      logic [127:0] z1, z2, zc, v4;
      logic [159:0] v5;
      logic [31:0]  s;
      int           t1, n;
      cyc = 0; total = 0; bad = 0; rnd_zero = 1'b1;
      rst_n = 1'b0;
      a_if.i_valid = 0; a_if.i_a = '0; a_if.o_ready = 1;
      b_if.i_valid = 0; b_if.i_a = '0; b_if.o_ready = 1;
      c_if.i_valid = 0; c_if.i_a = '0; c_if.o_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      checkResetA("rst0");
      checkOutput("rst0_B_i_ready", b_if.i_ready, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic sum with zero randomness.
      applyStimulus({32'd4, 32'd3, 32'd2, 32'd1}, 32'h0000000A);
      waitDrain("A_basic_drain");

      // Wrap-around and carry chain with random masks, issued back to back.
      rnd_zero = 1'b0;
      applyStimulus({32'h0, 32'h0, 32'h1, 32'hFFFFFFFF}, 32'h00000000);
      t1 = last_acc;
      applyStimulus({32'h0, 32'h0, 32'h1, 32'h7FFFFFFF}, 32'h80000000);
      checkOutput("A_throughput", last_acc - t1, LAT_A + 2);
      applyStimulus({32'hF0F0F0F0, 32'h0F0F0F0F, 32'h9ABCDEF0, 32'h12345678}, 32'hACF13567);
      waitDrain("A_carry_drain");

      // Back-pressure: hold o_ready low for five cycles once o_valid rises.
      a_if.o_ready = 1'b0;
      applyStimulus({32'd6, 32'd5, 32'd4, 32'd3}, 32'h00000012);
      n = 0;
      while (!a_if.o_valid && n < 100) begin @(negedge clk); n++; end
      checkOutput("A_bp_valid_seen", a_if.o_valid, 1);
      zc = a_if.o_z;
      repeat (5) begin
         checkOutput("A_bp_o_valid", a_if.o_valid, 1);
         checkOutput("A_bp_o_z_stable", a_if.o_z == zc, 1);
         checkOutput("A_bp_i_ready", a_if.i_ready, 0);
         checkOutput("A_bp_rnd_req", a_if.rnd_req, 0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      a_if.o_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("A_bp_release_o_valid", a_if.o_valid, 0);
      checkOutput("A_bp_release_i_ready", a_if.i_ready, 1);
      waitDrain("A_bp_drain");

      // Reset in the middle of a conversion, then a clean conversion.
      applyStimulus({32'd9, 32'd9, 32'd9, 32'd9}, 32'h00000024);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("A_busy_mid", a_if.busy, 1);
      rst_n = 1'b0;
      #1;
      checkResetA("rst_mid");
      qa.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      applyStimulus({32'd8, 32'd7, 32'd6, 32'd5}, 32'h0000001A);
      waitDrain("A_after_reset_drain");

      // Same input twice: same secret, different individual shares.
      v4 = {32'h55555555, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};
      s = v4[31:0] + v4[63:32] + v4[95:64] + v4[127:96];
      applyStimulus(v4, s);
      waitDrain("A_rnd1_drain");
      z1 = last_z_a;
      applyStimulus(v4, s);
      waitDrain("A_rnd2_drain");
      z2 = last_z_a;
      checkOutput("A_shares_differ", z1 != z2, 1);

      // Small instance N=2, K=8.
      applyStimulusB({8'h80, 8'h80}, 8'h00);
      applyStimulusB({8'h01, 8'h7F}, 8'h80);
      applyStimulusB({8'h34, 8'h12}, 8'h46);
      applyStimulusB({8'hFF, 8'hFF}, 8'hFE);
      waitDrain("B_drain");

      // Wide instance N=5, K=32.
      applyStimulusC({5{32'hFFFFFFFF}}, 32'hFFFFFFFB);
      for (int t = 0; t < 500; t++) begin
         s = 0;
         for (int w = 0; w < 5; w++) begin
            v5[w*32 +: 32] = $urandom;
            s += v5[w*32 +: 32];
         end
         applyStimulusC(v5, s);
      end
      waitDrain("C_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: time limit reached, got=running required=finished");
      $fatal(1, "[TB] watchdog");
   end
endmodule

// File: doc/sec_a2b_iter.md
# sec_a2b_iter

Iterative, arbitrary-order arithmetic-to-Boolean mask converter: takes `N_SHARES` arithmetic shares modulo 2^`K_WIDTH` and returns `N_SHARES` Boolean shares of the same secret. It is the area-optimised, any-`N` successor of the fixed-order pipelined SecA2B_nX converters. A single DOM-AND layer is time-multiplexed across `N_SHARES-1` masked Kogge-Stone additions. It sits behind the masked-arithmetic datapath and adds valid/ready handshakes on both sides, plus a randomness-request strobe.

## Interface
Parameters:
- `K_WIDTH`, 32: share width in bits, ≥ 2; arithmetic modulus 2^`K_WIDTH`.
- `N_SHARES`, 4: share count, ≥ 2.
- `L` (localparam), `$clog2(K_WIDTH-1)`: number of prefix rounds.
- `RNDW` (localparam), `N_SHARES*(N_SHARES-1)*K_WIDTH`: fresh random bits per cycle.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_valid`  in  1  input transaction valid.
- `i_ready`  out  1  block can accept input.
- `i_a`  in  `N_SHARES*K_WIDTH`  arithmetic shares; share j is `i_a[j*K_WIDTH +: K_WIDTH]`.
- `rnd`  in  `RNDW`  fresh randomness; sampled only when `rnd_req`=1.
- `rnd_req`  out  1  randomness is consumed in this cycle.
- `o_valid`  out  1  result valid.
- `o_ready`  in  1  downstream accepts the result.
- `o_z`  out  `N_SHARES*K_WIDTH`  Boolean shares, packed the same way as `i_a`.
- `busy`  out  1  conversion in progress (states GEN or PREFIX).

## Operation
- FSM states: IDLE, GEN, PREFIX, DONE.
- IDLE:
  - `i_ready`=1.
  - On `i_valid`, latch `i_a` into a share buffer.
  - Set Boolean accumulator x = (a0, 0, …, 0), operand index j=1, then go to GEN.
- Operand y for addition j is the Boolean sharing (a_j, 0, …, 0).
- GEN, 1 cycle:
  - p ← x⊕y (sharewise).
  - g ← SecAND(x, y).
  - Round counter r←0, then go to PREFIX.
- PREFIX, `L` cycles, with shift s = 2^r:
  - g ← g ⊕ SecAND(p, g<<s).
  - p ← SecAND(p, p<<s).
  - Shifts are logical left per share and zero-fill; bits shifted past `K_WIDTH-1` are dropped (mod 2^K).
  - The p update is skipped (don't-care) on the last round.
- On the last PREFIX cycle:
  - x ← x⊕y⊕(g_next<<1).
  - If j = `N_SHARES-1`, go to DONE; otherwise j←j+1 and go to GEN.
- SecAND is a DOM-independent gadget with 1-cycle registered output:
  - z_i = x_i·y_i ⊕ ⊕_{k≠i}(x_i·y_k ⊕ r_{ik}), where r_{ik}=r_{ki}, so there is one K-bit word per unordered pair.
  - Two gadgets per cycle, so `RNDW` bits per cycle.
  - `rnd` word packing: gadget 0 pairs first, then gadget 1 pairs; pairs ordered lexicographically (i<k).
- GEN uses only gadget 0; gadget 1 `rnd` is ignored in that cycle.
- `rnd_req`=1 exactly in GEN and PREFIX cycles.
- DONE:
  - `o_valid`=1 and `o_z`=x.
  - `o_z` is held stable until `o_ready`, then go to IDLE.
  - `i_ready`=0, so there is no overlap with the next transaction.
- Correctness: XOR of all `o_z` shares = (Σ a_j) mod 2^`K_WIDTH`, for any `rnd` values.
- Masking: no unmasked secret is formed in any register, and no two shares of one variable are combined combinationally outside the gadget.

## Timing
- Reset values:
  - state=IDLE, `i_ready`=1, `o_valid`=0, `rnd_req`=0, `busy`=0, `o_z`=0.
  - Share buffer, x, p, g, and counters all reset to 0.
- Acceptance at edge T means `o_valid` rises at edge T + (`N_SHARES-1`)·(1+`L`).
  - N=4, K=32: 18 cycles.
  - N=2, K=8: 4 cycles.
- `rnd_req` is high for exactly (`N_SHARES-1`)·(1+`L`) consecutive cycles per transaction.
- Back-to-back throughput: one result per (`N_SHARES-1`)·(1+`L`) + 2 cycles when `o_ready` is held at 1.
  - The extra cycles are DONE and IDLE.
- `i_valid` while `i_ready`=0 is ignored; the upstream must hold it.
- `rst_n` low mid-transaction: all state clears immediately (asynchronous), with no partial output. After release, the next accepted input converts correctly.

## Test plan
- N=4, K=32, rnd=0, a={1,2,3,4}: `o_valid` 18 cycles after acceptance; XOR(o_z)=0x0000000A; `rnd_req` high 18 cycles.
- N=4, K=32, a={0xFFFFFFFF,1,0,0}, random rnd: XOR(o_z)=0x00000000 (wrap-around); carry-chain case a={0x7FFFFFFF,1,0,0} gives 0x80000000.
- Back-pressure: `o_ready`=0 for 5 cycles after `o_valid` rises: `o_z` and `o_valid` stable, `i_ready`=0, `rnd_req`=0; completes on the first `o_ready`=1 cycle.
- Reset pulse at cycle 7 of a transaction: all outputs return to reset values; next transaction a={5,6,7,8} gives XOR(o_z)=0x1A.
- Parameter sweep N=2, K=8, a={0x80,0x80}: latency 4, XOR(o_z)=0x00. N=5, K=32: 500 random vectors, all XOR(o_z)=Σa mod 2^32.
- Randomness check: same `i_a` run twice with different rnd gives identical XOR(o_z) but differing individual shares.
